// File: rtl/ucie_phy_train_resp.sv
// UCIe PHY link-training responder.
// Walks a lane group through clock settle, optional per-lane equalisation and a
// final lane-count check, then reports per-lane results until the request drops.
module ucie_phy_train_resp #(
    parameter int NUM_LANES     = 64,
    parameter int SETTLE_CYCLES = 16,
    parameter int EQ_TIMEOUT    = 256,
    parameter int MIN_LANES     = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 training_enable,
    input  logic [3:0]           training_mode,
    input  logic [NUM_LANES-1:0] lane_enable,
    input  logic [NUM_LANES-1:0] eq_adaptation_enable,
    input  logic [NUM_LANES-1:0] lane_eq_done,
    output logic                 training_complete,
    output logic [7:0]           training_status,
    output logic [NUM_LANES-1:0] lane_status,
    output logic [NUM_LANES-1:0] lane_trained,
    output logic [NUM_LANES-1:0] lane_failed,
    output logic [NUM_LANES-1:0] eq_converged
);

    // One down-counter serves both timed phases, so it is sized for the longer one.
    localparam int CNT_MAX = (SETTLE_CYCLES > EQ_TIMEOUT) ? SETTLE_CYCLES : EQ_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int POP_W   = $clog2(NUM_LANES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_EQ     = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_FAIL   = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           mode_q, mode_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_LANES-1:0] conv_q, conv_d;
    logic [NUM_LANES-1:0] trained_q, trained_d;
    logic [NUM_LANES-1:0] failed_q, failed_d;

    logic [NUM_LANES-1:0] convNext;
    logic [NUM_LANES-1:0] goodLanes;
    logic [POP_W-1:0]     popCount;

    // Converged set as it will be after this cycle's EQ-lock pulses are folded in.
    assign convNext  = conv_q | (lane_eq_done & mask_q);
    assign goodLanes = mask_q & conv_q;

    // Count the requested lanes that converged, for the minimum-lane check.
    always_comb begin
        popCount = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            popCount = popCount + POP_W'(goodLanes[i]);
        end
    end

    // State register and all training bookkeeping; reset clears everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            conv_q    <= '0;
            trained_q <= '0;
            failed_q  <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            conv_q    <= conv_d;
            trained_q <= trained_d;
            failed_q  <= failed_d;
        end
    end

    // Next-state logic; a dropped request from any active state aborts to IDLE.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        conv_d    = conv_q;
        trained_d = trained_q;
        failed_d  = failed_q;

        case (state_q)
            S_IDLE: begin
                mode_d    = '0;
                mask_d    = '0;
                cnt_d     = '0;
                conv_d    = '0;
                trained_d = '0;
                failed_d  = '0;
                if (training_enable) begin
                    mode_d = training_mode;
                    mask_d = lane_enable;
                    if (training_mode == 4'd0 || training_mode == 4'd1) begin
                        state_d = S_SETTLE;
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        state_d  = S_FAIL;
                        failed_d = lane_enable;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    if (mode_q == 4'd0) begin
                        state_d = S_EQ;
                        cnt_d   = CNT_W'(EQ_TIMEOUT - 1);
                        conv_d  = mask_q & ~eq_adaptation_enable;
                    end else begin
                        state_d = S_CHECK;
                        conv_d  = mask_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EQ: begin
                conv_d = convNext;
                if (convNext == mask_q || cnt_q == '0) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CHECK: begin
                trained_d = mask_q & conv_q;
                failed_d  = mask_q & ~conv_q;
                state_d   = (popCount >= POP_W'(MIN_LANES)) ? S_DONE : S_FAIL;
            end
            S_DONE, S_FAIL: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE && !training_enable) begin
            state_d   = S_IDLE;
            mode_d    = '0;
            mask_d    = '0;
            cnt_d     = '0;
            conv_d    = '0;
            trained_d = '0;
            failed_d  = '0;
        end
    end

    // Per-lane status view depends on the phase the link is in.
    always_comb begin
        lane_status = '0;
        case (state_q)
            S_SETTLE, S_EQ, S_CHECK: lane_status = mask_q;
            S_DONE:                  lane_status = trained_q;
            default:                 lane_status = '0;
        endcase
    end

    assign training_complete = (state_q == S_DONE);
    assign training_status   = {mode_q, (state_q == S_FAIL), state_q};
    assign lane_trained      = trained_q;
    assign lane_failed       = failed_q;
    assign eq_converged      = conv_q;

endmodule

// File: tb/tb_ucie_phy_train_resp.sv
// Self-checking bench for ucie_phy_train_resp with an 8-lane configuration.
module tb_ucie_phy_train_resp;

    logic       clk;
    logic       resetn;
    logic       training_enable;
    logic [3:0] training_mode;
    logic [7:0] lane_enable;
    logic [7:0] eq_adaptation_enable;
    logic [7:0] lane_eq_done;
    logic       training_complete;
    logic [7:0] training_status;
    logic [7:0] lane_status;
    logic [7:0] lane_trained;
    logic [7:0] lane_failed;
    logic [7:0] eq_converged;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0] mode;
        logic [7:0] mask;
        logic [7:0] adapt;
        logic [7:0] doneMask;
        int         doneCycle;
        int         latency;
        logic [7:0] status;
        logic [7:0] trained;
        logic [7:0] failed;
        logic [7:0] conv;
        logic       complete;
    } vec_t;

    vec_t vecs[11];
    vec_t expQ[$];

    ucie_phy_train_resp #(
        .NUM_LANES    (8),
        .SETTLE_CYCLES(16),
        .EQ_TIMEOUT   (256),
        .MIN_LANES    (4)
    ) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .training_enable     (training_enable),
        .training_mode       (training_mode),
        .lane_enable         (lane_enable),
        .eq_adaptation_enable(eq_adaptation_enable),
        .lane_eq_done        (lane_eq_done),
        .training_complete   (training_complete),
        .training_status     (training_status),
        .lane_status         (lane_status),
        .lane_trained        (lane_trained),
        .lane_failed         (lane_failed),
        .eq_converged        (eq_converged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".status"},   32'(training_status),   32'h0);
        checkOutput({tag, ".complete"}, 32'(training_complete), 32'h0);
        checkOutput({tag, ".laneStat"}, 32'(lane_status),       32'h0);
        checkOutput({tag, ".trained"},  32'(lane_trained),      32'h0);
        checkOutput({tag, ".failed"},   32'(lane_failed),       32'h0);
        checkOutput({tag, ".conv"},     32'(eq_converged),      32'h0);
    endtask

    task automatic applyStimulus(input vec_t v);
        training_mode        = v.mode;
        lane_enable          = v.mask;
        eq_adaptation_enable = v.adapt;
        lane_eq_done         = 8'h00;
        training_enable      = 1'b1;
        expQ.push_back(v);
    endtask

    task automatic runVector(input vec_t v, input int idx);
        vec_t  exp;
        int    edges;
        int    eqCycle;
        bit    done;
        string tag;
        tag = $sformatf("v%0d", idx);
        applyStimulus(v);
        edges   = 0;
        eqCycle = 0;
        done    = 1'b0;
        while (!done && edges < 400) begin
            tick();
            edges++;
            if (edges == 1) begin
                lane_enable   = ~v.mask;
                training_mode = 4'hF;
            end
            if (training_status[2:0] == 3'd2) begin
                eqCycle++;
                lane_eq_done = (eqCycle == v.doneCycle) ? v.doneMask : 8'h00;
            end else begin
                lane_eq_done = 8'h00;
            end
            if (training_status[2:0] == 3'd4 || training_status[2:0] == 3'd5)
                done = 1'b1;
        end
        lane_eq_done = 8'h00;
        if (!done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s.timeout: no terminal state after %0d cycles", tag, edges);
        end
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s.scoreboard: queue empty", tag);
            return;
        end
        exp = expQ.pop_front();
        checkOutput({tag, ".latency"},  32'(edges),             32'(exp.latency));
        checkOutput({tag, ".status"},   32'(training_status),   32'(exp.status));
        checkOutput({tag, ".complete"}, 32'(training_complete), 32'(exp.complete));
        checkOutput({tag, ".trained"},  32'(lane_trained),      32'(exp.trained));
        checkOutput({tag, ".failed"},   32'(lane_failed),       32'(exp.failed));
        checkOutput({tag, ".conv"},     32'(eq_converged),      32'(exp.conv));
        checkOutput({tag, ".laneStat"}, 32'(lane_status),
                    32'(exp.complete ? exp.trained : 8'h00));
        tick();
        tick();
        checkOutput({tag, ".hold"},     32'(training_status),   32'(exp.status));
        training_enable = 1'b0;
        tick();
        checkAllZero({tag, ".idle"});
    endtask

    initial begin
        vecs[0]  = '{4'd0, 8'hFF, 8'hFF, 8'hFF, 10,  28,  8'h04, 8'hFF, 8'h00, 8'hFF, 1'b1};
        vecs[1]  = '{4'd0, 8'hFF, 8'hFF, 8'h1F, 5,   274, 8'h04, 8'h1F, 8'hE0, 8'h1F, 1'b1};
        vecs[2]  = '{4'd0, 8'h0F, 8'hFF, 8'h01, 3,   274, 8'h0D, 8'h01, 8'h0E, 8'h01, 1'b0};
        vecs[3]  = '{4'd1, 8'hF0, 8'hFF, 8'h00, 0,   18,  8'h14, 8'hF0, 8'h00, 8'hF0, 1'b1};
        vecs[4]  = '{4'd5, 8'hA5, 8'hFF, 8'h00, 0,   1,   8'h5D, 8'h00, 8'hA5, 8'h00, 1'b0};
        vecs[5]  = '{4'd0, 8'hF0, 8'hFF, 8'hF0, 256, 274, 8'h04, 8'hF0, 8'h00, 8'hF0, 1'b1};
        vecs[6]  = '{4'd0, 8'hFF, 8'h0F, 8'h0F, 2,   20,  8'h04, 8'hFF, 8'h00, 8'hFF, 1'b1};
        vecs[7]  = '{4'd0, 8'h00, 8'hFF, 8'h00, 0,   19,  8'h0D, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{4'd0, 8'h0F, 8'hFF, 8'hFF, 4,   22,  8'h04, 8'h0F, 8'h00, 8'h0F, 1'b1};
        vecs[9]  = '{4'd1, 8'h07, 8'hFF, 8'h00, 0,   18,  8'h1D, 8'h07, 8'h00, 8'h07, 1'b0};
        vecs[10] = '{4'd2, 8'hFF, 8'hFF, 8'h00, 0,   1,   8'h2D, 8'h00, 8'hFF, 8'h00, 1'b0};

        resetn               = 1'b0;
        training_enable      = 1'b0;
        training_mode        = 4'd0;
        lane_enable          = 8'h00;
        eq_adaptation_enable = 8'h00;
        lane_eq_done         = 8'h00;
        tick();
        tick();
        checkAllZero("reset");
        resetn = 1'b1;
        tick();
        checkAllZero("postReset");

        for (int i = 0; i < 11; i++) begin
            runVector(vecs[i], i);
        end

        // Abort by dropping the request during EQ cycle 3.
        begin
            vec_t v;
            int   edges;
            int   eqCycle;
            v = vecs[0];
            training_mode        = 4'd0;
            lane_enable          = 8'hFF;
            eq_adaptation_enable = 8'hFF;
            training_enable      = 1'b1;
            tick();
            checkOutput("abort.settleStatus", 32'(training_status), 32'h01);
            checkOutput("abort.settleLanes",  32'(lane_status),     32'hFF);
            edges   = 1;
            eqCycle = 0;
            while (eqCycle < 3 && edges < 100) begin
                tick();
                edges++;
                if (training_status[2:0] == 3'd2) eqCycle++;
            end
            checkOutput("abort.eqStatus", 32'(training_status), 32'h02);
            checkOutput("abort.eqLanes",  32'(lane_status),     32'hFF);
            training_enable = 1'b0;
            tick();
            checkAllZero("abort");
            runVector(vecs[3], 100);
        end

        // Asynchronous reset in the middle of SETTLE.
        begin
            training_mode   = 4'd1;
            lane_enable     = 8'h3C;
            training_enable = 1'b1;
            for (int k = 0; k < 5; k++) tick();
            checkOutput("rstMid.settleStatus", 32'(training_status), 32'h11);
            checkOutput("rstMid.settleLanes",  32'(lane_status),     32'h3C);
            resetn = 1'b0;
            #1;
            checkAllZero("rstMid");
            training_enable = 1'b0;
            tick();
            resetn = 1'b1;
            tick();
            runVector(vecs[3], 101);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ucie_phy_train_resp.md
UCIE_PHY_TRAIN_RESP -- requirements
Module: ucie_phy_train_resp

Interface
REQ-001 SHALL have parameter NUM_LANES, default 64, number of physical lanes.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, clock-settle phase length in cycles (>=1).
REQ-003 SHALL have parameter EQ_TIMEOUT, default 256, maximum EQ phase length in cycles (>=1).
REQ-004 SHALL have parameter MIN_LANES, default 1, minimum trained lanes for success (1..NUM_LANES).
REQ-005 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port resetn  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port training_enable  in  1  training request level from controller.
REQ-008 SHALL have port training_mode  in  4  0=full (settle+EQ), 1=fast (settle only), 2..15 reserved.
REQ-009 SHALL have port lane_enable  in  NUM_LANES  lanes requested for training.
REQ-010 SHALL have port eq_adaptation_enable  in  NUM_LANES  per-lane EQ participation.
REQ-011 SHALL have port lane_eq_done  in  NUM_LANES  per-lane EQ-lock pulse/level from analog front end.
REQ-012 SHALL have port training_complete  out  1  high while in DONE.
REQ-013 SHALL have port training_status  out  8  {mode_q[3:0], error, state[2:0]}.
REQ-014 SHALL have ports lane_status, lane_trained, lane_failed, eq_converged  out  NUM_LANES each  per-lane status.

Function
REQ-015 SHALL implement states IDLE=0, SETTLE=1, EQ=2, CHECK=3, DONE=4, FAIL=5, encoded in training_status[2:0].
REQ-016 IDLE, training_enable=1: SHALL latch mode_q=training_mode and mask_q=lane_enable in the same cycle; next state SETTLE if mode_q is 0 or 1, else FAIL.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles (down-counter loaded on entry), then go to EQ (mode 0) or CHECK (mode 1).
REQ-018 On EQ entry, eq_converged SHALL be set for bits in mask_q & ~eq_adaptation_enable.
REQ-019 In EQ, eq_converged[i] SHALL set and stay set (sticky) when lane_eq_done[i] & mask_q[i]; unmasked bits SHALL stay 0.
REQ-020 EQ SHALL exit to CHECK on the first cycle eq_converged==mask_q, or after EQ_TIMEOUT cycles in EQ, whichever comes first.
REQ-021 A lane_eq_done arriving in the same cycle as the timeout SHALL count as converged.
REQ-022 In mode 1, eq_converged SHALL equal mask_q on entry to CHECK.
REQ-023 CHECK SHALL last one cycle and register lane_trained=mask_q & eq_converged and lane_failed=mask_q & ~eq_converged.
REQ-024 CHECK SHALL go to DONE if popcount(mask_q & eq_converged) >= MIN_LANES, else FAIL; popcount width SHALL be $clog2(NUM_LANES+1).
REQ-025 Reserved-mode FAIL SHALL set lane_failed=mask_q and lane_trained=0.
REQ-026 error bit SHALL be 1 only in FAIL.
REQ-027 DONE and FAIL SHALL hold all outputs until training_enable=0.
REQ-028 training_enable=0 in any non-IDLE state SHALL go to IDLE next cycle, aborting mid-training.
REQ-029 Entering IDLE SHALL clear lane_trained, lane_failed, eq_converged, counters, mode_q and mask_q.
REQ-030 lane_status SHALL equal mask_q in SETTLE/EQ/CHECK, lane_trained in DONE, and 0 in IDLE/FAIL.
REQ-031 mask_q==0 SHALL reach FAIL via CHECK whenever MIN_LANES>=1.
REQ-032 Changes on lane_enable or training_mode after latching SHALL be ignored until the next IDLE exit.

Reset
REQ-033 resetn=0 SHALL asynchronously force IDLE and drive every output and internal register to 0; the first training_enable is sampled on the first clk edge after resetn=1.

Verification (NUM_LANES=8, SETTLE_CYCLES=16, EQ_TIMEOUT=256, MIN_LANES=4)
REQ-034 Full mode, lane_enable=8'hFF, eq_adaptation_enable=8'hFF, all lane_eq_done at EQ cycle 10 -> CHECK after EQ cycle 10; lane_trained=8'hFF, training_complete=1, training_status=8'h04.
REQ-035 Full mode, mask 8'hFF, lanes 0-4 done, 5-7 never done -> exit EQ after 256 cycles; lane_trained=8'h1F, lane_failed=8'hE0, DONE.
REQ-036 Full mode, mask 8'h0F, only lane 0 done -> timeout; lane_failed=8'h0E; FAIL; training_status=8'h0D.
REQ-037 Mode 1, mask 8'hF0 -> DONE exactly 18 cycles after the enable cycle (16 SETTLE + CHECK + DONE register); eq_converged=8'hF0. Mode 5 -> FAIL next cycle; training_status=8'h5D; lane_failed=mask.
REQ-038 Deassert training_enable in EQ cycle 3, and separately assert resetn=0 mid-SETTLE -> IDLE next cycle (or immediately on reset); all outputs 0; a fresh request restarts from a full SETTLE.
